// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Per-op settle time, divide-by-zero trap, valid/ready on both sides.
module alu_arbiter #(
   parameter int N         = 32,
   parameter int SHORT_LAT = 1,
   parameter int LONG_LAT  = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [2:0]   req0_sel,
   input  logic [N-1:0] req0_op1,
   input  logic [N-1:0] req0_op2,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic         rsp0_err,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [2:0]   req1_sel,
   input  logic [N-1:0] req1_op1,
   input  logic [N-1:0] req1_op2,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic         rsp1_err,
   output logic [N-1:0] rsp_data,
   output logic [2:0]   alu_sel,
   output logic [N-1:0] alu_op1,
   output logic [N-1:0] alu_op2,
   input  logic [N-1:0] alu_q,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   localparam int MAXL = (LONG_LAT > SHORT_LAT) ? LONG_LAT : SHORT_LAT;
   localparam int CW   = $clog2(MAXL + 1);

   state_t         state;
   logic           rr_ptr;
   logic           owner;
   logic           err;
   logic [CW-1:0]  cnt;

   logic           grant;
   logic           take;
   logic [2:0]     sel;
   logic [N-1:0]   op1;
   logic [N-1:0]   op2;
   logic           is_long;
   logic           div_zero;
   logic           rsp_done;

   // rr_ptr only breaks ties; a lone valid always wins
   always_comb begin
      grant = rr_ptr;
      unique case (1'b1)
         req0_valid & ~req1_valid: grant = 1'b0;
         req1_valid & ~req0_valid: grant = 1'b1;
         default:                  grant = rr_ptr;
      endcase
   end

   assign req0_ready = (state == IDLE) & req0_valid & ~grant;
   assign req1_ready = (state == IDLE) & req1_valid & grant;
   assign take       = req0_ready | req1_ready;

   assign sel      = grant ? req1_sel : req0_sel;
   assign op1      = grant ? req1_op1 : req0_op1;
   assign op2      = grant ? req1_op2 : req0_op2;
   assign is_long  = (sel == 3'd2) | (sel == 3'd3);
   assign div_zero = (sel == 3'd3) & (op2 == '0);

   assign rsp0_valid = (state == RESP) & ~owner;
   assign rsp1_valid = (state == RESP) & owner;
   assign rsp0_err   = rsp0_valid & err;
   assign rsp1_err   = rsp1_valid & err;
   assign rsp_done   = (rsp0_valid & rsp0_ready)
                     | (rsp1_valid & rsp1_ready);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= 1'b0;
         owner    <= 1'b0;
         err      <= 1'b0;
         cnt      <= '0;
         rsp_data <= '0;
         alu_sel  <= '0;
         alu_op1  <= '0;
         alu_op2  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  alu_sel <= sel;
                  alu_op1 <= op1;
                  alu_op2 <= op2;
                  owner   <= grant;
                  rr_ptr  <= ~grant;
                  if (div_zero) begin
                     rsp_data <= '0;
                     err      <= 1'b1;
                     state    <= RESP;
                  end else begin
                     cnt   <= is_long ? CW'(LONG_LAT - 1)
                                      : CW'(SHORT_LAT - 1);
                     state <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  rsp_data <= alu_q;
                  err      <= 1'b0;
                  state    <= RESP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: begin
               if (rsp_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scenarios plus randomized traffic for alu_arbiter,
// checked against a transaction-level model of grant order and latency.
module tb_alu_arbiter;

   localparam int N     = 32;
   localparam int SHORT = 1;
   localparam int LONG  = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         v [2];
   logic [2:0]   sl [2];
   logic [N-1:0] o1 [2];
   logic [N-1:0] o2 [2];
   logic         rr [2];
   logic         rdy [2];
   logic         rv [2];
   logic         re [2];
   logic [N-1:0] rsp_data;
   logic [2:0]   alu_sel;
   logic [N-1:0] alu_op1;
   logic [N-1:0] alu_op2;
   logic [N-1:0] alu_q;
   logic         busy;
   logic         req0_ready, req1_ready;
   logic         rsp0_valid, rsp1_valid;
   logic         rsp0_err, rsp1_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   function automatic logic [N-1:0] ref_alu(
      input logic [2:0] s,
      input logic [N-1:0] a,
      input logic [N-1:0] b
   );
      case (s)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a * b;
         3'd3: return (b == '0) ? '0 : a / b;
         3'd4: return a & b;
         3'd5: return a | b;
         3'd6: return ~a;
         default: return '0;
      endcase
   endfunction

   always_comb alu_q = ref_alu(alu_sel, alu_op1, alu_op2);

   assign rdy[0] = req0_ready;
   assign rdy[1] = req1_ready;
   assign rv[0]  = rsp0_valid;
   assign rv[1]  = rsp1_valid;
   assign re[0]  = rsp0_err;
   assign re[1]  = rsp1_err;

   alu_arbiter #(.N(N), .SHORT_LAT(SHORT), .LONG_LAT(LONG)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v[0]), .req0_ready(req0_ready),
      .req0_sel(sl[0]), .req0_op1(o1[0]), .req0_op2(o2[0]),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]),
      .rsp0_err(rsp0_err),
      .req1_valid(v[1]), .req1_ready(req1_ready),
      .req1_sel(sl[1]), .req1_op1(o1[1]), .req1_op2(o2[1]),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]),
      .rsp1_err(rsp1_err),
      .rsp_data(rsp_data),
      .alu_sel(alu_sel), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_q(alu_q), .busy(busy)
   );

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic drive(input int r, input logic [2:0] s,
                        input logic [N-1:0] a, input logic [N-1:0] b);
      v[r] = 1'b1; sl[r] = s; o1[r] = a; o2[r] = b;
      #1;
   endtask

   task automatic wait_rsp(input int r, output int n);
      n = 1;
      while (!rv[r] && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic finish_rsp(input int r);
      rr[r] = 1'b1;
      tick();
      rr[r] = 1'b0;
      #1;
   endtask

   int n;
   int w;
   int prefer;
   int hold;
   int exp_lat;
   bit pend [2];
   logic [N-1:0] exp_d;
   logic [N-1:0] held;

   initial begin
      for (int r = 0; r < 2; r++) begin
         v[r] = 0; sl[r] = 0; o1[r] = 0; o2[r] = 0; rr[r] = 0;
      end
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_rdy0", rdy[0], 0);
      chk("rst_rsp", {rv[0], rv[1], re[0], re[1]}, 0);
      chk("rst_alu", {alu_sel, alu_op1, alu_op2}, 0);
      chk("rst_data", rsp_data, 0);
      do_reset();

      // 1: single ADD, LAT=1
      drive(0, 3'd0, 30, 20);
      chk("t1_ready", rdy[0], 1);
      tick();
      v[0] = 0;
      chk("t1_alu_sel", alu_sel, 0);
      chk("t1_alu_ops", {alu_op1, alu_op2}, {32'd30, 32'd20});
      chk("t1_early", rv[0], 0);
      tick();
      chk("t1_valid", rv[0], 1);
      chk("t1_data", rsp_data, 50);
      chk("t1_err", re[0], 0);
      finish_rsp(0);
      chk("t1_idle", busy, 0);

      // 2: contention from reset, ready tied high
      do_reset();
      rr[0] = 1; rr[1] = 1;
      drive(0, 3'd1, 30, 20);
      drive(1, 3'd5, 30, 20);
      chk("t2_rdy", {rdy[0], rdy[1]}, 2'b10);
      tick();
      v[0] = 0;
      #1;
      chk("t2_exec_rdy1", rdy[1], 0);
      tick();
      chk("t2_v0", rv[0], 1);
      chk("t2_d0", rsp_data, 10);
      chk("t2_resp_rdy1", rdy[1], 0);
      tick();
      chk("t2_gap_rdy1", rdy[1], 1);
      tick();
      v[1] = 0;
      tick();
      chk("t2_v1", rv[1], 1);
      chk("t2_d1", rsp_data, 32'h1E);
      tick();
      rr[0] = 0; rr[1] = 0;
      #1;

      // 3: MUL latency
      drive(1, 3'd2, 30, 20);
      chk("t3_ready", rdy[1], 1);
      tick();
      v[1] = 0;
      n = 1;
      while (!rv[1] && n < 40) begin
         chk("t3_busy", busy, 1);
         tick();
         n++;
      end
      chk("t3_lat", n, 5);
      chk("t3_data", rsp_data, 600);
      chk("t3_busy_resp", busy, 1);
      finish_rsp(1);

      // 4: divide by zero trap
      drive(0, 3'd3, 30, 0);
      chk("t4_ready", rdy[0], 1);
      tick();
      v[0] = 0;
      chk("t4_valid", rv[0], 1);
      chk("t4_err", re[0], 1);
      chk("t4_data", rsp_data, 0);
      chk("t4_alu", {alu_sel, alu_op2}, {3'd3, 32'd0});
      finish_rsp(0);

      // 5: response back-pressure blocks the other requester
      drive(0, 3'd0, 1, 2);
      chk("t5_ready0", rdy[0], 1);
      tick();
      v[0] = 0;
      drive(1, 3'd0, 5, 6);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("t5_hold_v", rv[0], 1);
         chk("t5_hold_d", rsp_data, 3);
         chk("t5_hold_rdy1", rdy[1], 0);
         tick();
      end
      finish_rsp(0);
      chk("t5_grant1", rdy[1], 1);
      tick();
      v[1] = 0;
      wait_rsp(1, n);
      chk("t5_d1", rsp_data, 11);
      finish_rsp(1);

      // 6: reset during EXEC
      drive(0, 3'd2, 7, 8);
      tick();
      v[0] = 0;
      tick();
      chk("t6_in_exec", busy, 1);
      rst_n = 0;
      #1;
      chk("t6_rst_outs", {busy, rv[0], rv[1], re[0], re[1]}, 0);
      chk("t6_rst_alu", {alu_sel, alu_op1, alu_op2}, 0);
      chk("t6_rst_data", rsp_data, 0);
      tick();
      rst_n = 1;
      tick();
      chk("t6_no_rsp", {rv[0], rv[1]}, 0);
      drive(1, 3'd4, 12, 10);
      chk("t6_req1", rdy[1], 1);
      tick();
      v[1] = 0;
      wait_rsp(1, n);
      chk("t6_d1", rsp_data, 8);
      finish_rsp(1);
      drive(0, 3'd0, 1, 1);
      drive(1, 3'd0, 2, 2);
      chk("t6_contend", {rdy[0], rdy[1]}, 2'b10);
      tick();
      v[0] = 0;
      wait_rsp(0, n);
      chk("t6_d0", rsp_data, 2);
      finish_rsp(0);
      chk("t6_then1", rdy[1], 1);
      tick();
      v[1] = 0;
      wait_rsp(1, n);
      finish_rsp(1);

      // randomized traffic against the transaction model
      do_reset();
      prefer = 0;
      pend[0] = 0; pend[1] = 0;
      for (int it = 0; it < 150; it++) begin
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
               pend[r] = 1;
               sl[r] = 3'($urandom_range(0, 7));
               o1[r] = $urandom;
               o2[r] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            end
         end
         if (!pend[0] && !pend[1]) begin
            w = $urandom_range(0, 1);
            pend[w] = 1;
            sl[w] = 3'($urandom_range(0, 7));
            o1[w] = $urandom;
            o2[w] = $urandom;
         end
         v[0] = pend[0]; v[1] = pend[1];
         #1;
         w = (pend[0] && pend[1]) ? prefer : (pend[0] ? 0 : 1);
         chk("rnd_grant", {rdy[0], rdy[1]}, (w == 0) ? 2'b10 : 2'b01);
         if ((sl[w] == 3'd3) && (o2[w] == '0)) begin
            exp_lat = 1;
            exp_d = '0;
         end else begin
            exp_lat = ((sl[w] == 3'd2) || (sl[w] == 3'd3)) ? LONG + 1 : SHORT + 1;
            exp_d = ref_alu(sl[w], o1[w], o2[w]);
         end
         tick();
         pend[w] = 0;
         v[w] = 0;
         prefer = 1 - w;
         wait_rsp(w, n);
         chk("rnd_lat", n, exp_lat);
         chk("rnd_data", rsp_data, exp_d);
         chk("rnd_err", re[w], (exp_lat == 1));
         chk("rnd_other", {rv[1-w], rdy[1-w]}, 0);
         held = rsp_data;
         hold = $urandom_range(0, 2);
         for (int i = 0; i < hold; i++) begin
            tick();
            chk("rnd_hold", {rv[w], rsp_data}, {1'b1, held});
         end
         finish_rsp(w);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
